ccd_pixel_capture: RTL

- Downstream neighbour of the CCD readout sequencer.
- Samples the 8-bit multiplexed output bus of the CDS/ADC front end, using the sequencer's ad_adclk and ad_oeb_n strobes, and assembles each pixel as a 16-bit word.
- Buffers pixels in a first-word-fall-through FIFO and presents them on a valid/ready stream to the host-transfer stage.
- Runs on the fast system clock. The strobes are slow and treated as asynchronous.

---
 rtl/ccd_pixel_capture.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ccd_pixel_capture.sv
// CCD pixel capture: syncs CDS/ADC byte strobes, pairs bytes into 16-bit pixels, FWFT FIFO to a valid/ready stream.
// Optional build macro CCD_PIXEL_CAPTURE_TEST_PATTERN_EN adds test_mode (pushes pixel_count[15:0] instead of ADC data).
module ccd_pixel_capture #(
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    ad_data,
  input  logic                          ad_adclk,
  input  logic                          ad_oeb_n,
  input  logic                          ccd_busy,
  input  logic                          arm,
`ifdef CCD_PIXEL_CAPTURE_TEST_PATTERN_EN
  input  logic                          test_mode,
`endif
  output logic [15:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              pixel_count,
  output logic                          overflow,
  output logic                          frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;
  typedef struct packed {
    logic        vld;
    logic [15:0] word;
  } push_t;

  // strobe synchronisers; data rides the same depth so the byte lines up with the detected edge
  logic       adclk_s1, adclk_s2, adclk_s3;
  logic       oeb_s1, oeb_s2;
  logic       busy_s1, busy_s2, busy_s3;
  logic [7:0] data_s1, data_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adclk_s1 <= 1'b0; adclk_s2 <= 1'b0; adclk_s3 <= 1'b0;
      oeb_s1   <= 1'b0; oeb_s2   <= 1'b0;
      busy_s1  <= 1'b0; busy_s2  <= 1'b0; busy_s3  <= 1'b0;
      data_s1  <= '0;   data_s2  <= '0;
    end else begin
      adclk_s1 <= ad_adclk; adclk_s2 <= adclk_s1; adclk_s3 <= adclk_s2;
      oeb_s1   <= ad_oeb_n; oeb_s2   <= oeb_s1;
      busy_s1  <= ccd_busy; busy_s2  <= busy_s1;  busy_s3  <= busy_s2;
      data_s1  <= ad_data;  data_s2  <= data_s1;
    end
  end

  logic adclk_rise, adclk_fall, busy_fall, byte_ok;
  assign adclk_rise = adclk_s2 & ~adclk_s3;
  assign adclk_fall = ~adclk_s2 & adclk_s3;
  assign busy_fall  = ~busy_s2 & busy_s3;
  assign byte_ok    = ~oeb_s2;

  state_t     state;
  logic [7:0] hi_byte;
  push_t      push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hi_byte    <= '0;
      push       <= '0;
      frame_done <= 1'b0;
    end else begin
      push.vld   <= 1'b0;
      frame_done <= 1'b0;
      if (arm) begin
        state <= S_HI;
      end else begin
        case (state)
          S_IDLE: ;
          S_HI: begin
            if (busy_fall) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else if (adclk_fall && byte_ok) begin
              hi_byte <= data_s2;
              state   <= S_LO;
            end
          end
          S_LO: begin
            // end of frame beats a pending low byte: the half pixel is dropped
            if (busy_fall) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else if (adclk_rise && byte_ok) begin
              push.vld  <= 1'b1;
              push.word <= {hi_byte, data_s2};
              state     <= S_HI;
            end else if (adclk_fall && byte_ok) begin
              hi_byte <= data_s2;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pop, accept;
  logic [15:0]   wdata;

  assign m_valid    = (count != '0);
  assign m_data     = m_valid ? mem[rd_ptr] : '0;
  assign fifo_level = count;
  assign pop        = m_valid & m_ready;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign accept     = push.vld & ((count != FULL_LVL) | pop);

`ifdef CCD_PIXEL_CAPTURE_TEST_PATTERN_EN
  assign wdata = test_mode ? pixel_count[15:0] : push.word;
`else
  assign wdata = push.word;
`endif

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pixel_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (arm) begin
        pixel_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (accept && (pixel_count != '1)) pixel_count <= pixel_count + 1'b1;
        if (push.vld && !accept)           overflow    <= 1'b1;
      end
    end
  end
endmodule
